b2a_issue_sched: RTL
====================

Name: b2a_issue_sched

Overview:
- Issue scheduler and result router for the masked Boolean-to-arithmetic conversion pipeline.
- Arbitrates round-robin among NREQ requesters and feeds one Boolean-masked operand per enabled cycle into the pipeline.
- Gates the pipeline's global enable on fresh-randomness availability and on result back-pressure.
- Tags each operand with its requester ID and returns each arithmetic-masked result with that tag through a one-entry output register.

Parameters:
- K_WIDTH, 16, bits per share.
- N_SHARES, 3, number of shares; MASKWIDTH = K_WIDTH*N_SHARES.
- NREQ, 4, number of requesters (>=2); TAGW = $clog2(NREQ).
- LAT, 12, pipeline dvld-to-ovld latency in enabled cycles. Must match the instantiated B2A pipeline.
- RANDNUM, 106, random words the pipeline consumes per enabled cycle; RND_W = K_WIDTH*RANDNUM.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  NREQ  per-requester operand valid.
- req_b  in  NREQ*MASKWIDTH  per-requester Boolean shares; slice i belongs to requester i.
- req_rdy  out  NREQ  one-hot grant; the operand is accepted when req_vld[i] and req_rdy[i] are both high.
- rng_vld  in  1  fresh randomness available.
- rng_rnd  in  RND_W  randomness word.
- rng_rdy  out  1  randomness consumed this cycle.
- p_dvld  out  1  pipeline input valid.
- p_ena  out  1  pipeline global enable.
- p_ib  out  MASKWIDTH  pipeline Boolean input.
- p_rnd  out  RND_W  pipeline randomness; equals rng_rnd.
- p_oa  in  MASKWIDTH  pipeline arithmetic output.
- p_ovld  in  1  pipeline output valid.
- out_vld  out  1  result valid.
- out_tag  out  TAGW  requester ID of the result.
- out_a  out  MASKWIDTH  arithmetic shares of the result.
- out_rdy  in  1  downstream accepts the result.
- inflight  out  $clog2(LAT+1)  number of operations currently inside the pipeline.
- err  out  1  sticky tag/ovld misalignment flag.

Behaviour:
- Reset (async, rst_n=0): out_vld=0, out_tag=0, out_a=0, inflight=0, err=0, RR pointer=NREQ-1, tag shift register cleared. An operation in flight at reset is discarded; no result emerges for it.
- Stall term: stall = out_vld & ~out_rdy.
- Enable: p_ena = rng_vld & ~stall; rng_rdy = p_ena. Randomness is consumed on every enabled cycle; the pipeline never advances without fresh randomness.
- Arbitration (combinational): when p_ena=1 and |req_vld, grant the first requester with req_vld=1 searching from ptr+1 modulo NREQ.
- Grant outputs: req_rdy = one-hot grant; p_dvld = |req_rdy; p_ib = req_b of the granted requester, 0 when there is no grant.
- When p_ena=0: req_rdy=0 and p_dvld=0.
- RR pointer: updates to the granted index only on a grant.
- Tag tracking: a LAT-deep shift register of {valid, tag} advances only when p_ena=1. Its input is {p_dvld, granted index}.
- Result register load: when p_ena=1 and p_ovld=1, load out_a=p_oa and out_tag=tail tag, and set out_vld=1.
  - If the tail valid bit is 0 at that moment, set err=1 and still load.
  - If the tail valid bit is 1 and p_ovld=0 while p_ena=1, set err=1; no result is emitted.
- Result register clear: out_vld clears when out_rdy=1 and there is no new load in the same cycle.
- Accept and load in the same cycle: the new result replaces the old one with out_vld held at 1. No bubble is inserted.
- Overwrite protection: because p_ena=0 whenever stall=1, a held result is never overwritten.
- inflight counter: +1 on a p_dvld cycle, -1 on an enabled cycle whose tail valid bit is 1; both in the same cycle leaves it unchanged. It saturates at LAT, which cannot be exceeded by construction.
- Throughput and latency: with rng_vld=1 and out_rdy=1, one issue per cycle and one result per cycle once the pipeline is full. Request-accept to out_vld is LAT+1 cycles.
- Stall timing: all pipeline state, the tag register and inflight freeze while p_ena=0. The latency counts enabled cycles only.

Test Plan:
- Single operation: reset, requester 2 presents Boolean shares XORing to 0x1234 with rng_vld=1 and out_rdy=1 -> out_vld rises exactly 13 cycles after acceptance, out_tag=2, arithmetic shares sum mod 2^16 to 0x1234, and inflight returns to 0.
- Fairness: all 4 requesters hold req_vld=1 for 8 cycles -> grants occur in order 0,1,2,3,0,1,2,3, and results return in the same tag order.
- Randomness starvation: rng_vld=0 for 5 cycles mid-stream -> p_ena=0, rng_rdy=0 and req_rdy=0 for those 5 cycles, and every result arrives exactly 5 cycles later than it would without the gap.
- Back-pressure: out_rdy=0 while a result is held -> p_ena=0, out_a/out_tag stable, no loss. Then out_rdy=1 -> back-to-back results with no duplicates.
- Reset mid-operation: rst_n pulses low with inflight=6 -> all outputs reach their reset values immediately; no stale result appears afterwards; err=0.
- Misalignment: a bench pipeline model emits p_ovld one cycle early -> err=1 and stays set until reset.

Source files
------------

// File: rtl/b2a_issue_sched.sv
// Issue scheduler and result router around a masked Boolean-to-arithmetic pipeline.
// Round-robin issue, randomness/back-pressure gated enable, tag tracking and a one-entry result register.
module b2a_issue_sched #(
    parameter int K_WIDTH  = 16,
    parameter int N_SHARES = 3,
    parameter int NREQ     = 4,
    parameter int LAT      = 12,
    parameter int RANDNUM  = 106,
    localparam int MASKWIDTH = K_WIDTH * N_SHARES,
    localparam int TAGW      = $clog2(NREQ),
    localparam int RND_W     = K_WIDTH * RANDNUM,
    localparam int CNTW      = $clog2(LAT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_vld,
    input  logic [NREQ*MASKWIDTH-1:0] req_b,
    output logic [NREQ-1:0]           req_rdy,
    input  logic                      rng_vld,
    input  logic [RND_W-1:0]          rng_rnd,
    output logic                      rng_rdy,
    output logic                      p_dvld,
    output logic                      p_ena,
    output logic [MASKWIDTH-1:0]      p_ib,
    output logic [RND_W-1:0]          p_rnd,
    input  logic [MASKWIDTH-1:0]      p_oa,
    input  logic                      p_ovld,
    output logic                      out_vld,
    output logic [TAGW-1:0]           out_tag,
    output logic [MASKWIDTH-1:0]      out_a,
    input  logic                      out_rdy,
    output logic [CNTW-1:0]           inflight,
    output logic                      err
);

    logic                 stall;
    logic                 ena;
    logic [TAGW-1:0]      ptr_reg;
    logic [NREQ-1:0]      grant;
    logic [TAGW-1:0]      grant_idx;
    logic [TAGW-1:0]      idx;
    logic                 found;
    logic [MASKWIDTH-1:0] gated_b [NREQ];
    logic [MASKWIDTH-1:0] ib_next;

    logic                 tag_vld_reg [LAT];
    logic [TAGW-1:0]      tag_reg     [LAT];
    logic                 tail_vld;
    logic [TAGW-1:0]      tail_tag;
    logic                 load;
    logic                 retire;

    logic                 out_vld_reg;
    logic [TAGW-1:0]      out_tag_reg;
    logic [MASKWIDTH-1:0] out_a_reg;
    logic [CNTW-1:0]      inflight_reg;
    logic                 err_reg;

    // A held result blocks the whole pipeline so it can never be overwritten.
    assign stall   = out_vld_reg & ~out_rdy;
    assign ena     = rng_vld & ~stall;
    assign p_ena   = ena;
    assign rng_rdy = ena;
    assign p_rnd   = rng_rnd;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = TAGW'((int'(ptr_reg) + k) % NREQ);
            if (ena && !found && req_vld[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                grant_idx    = idx;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
        assign gated_b[gi] = grant[gi] ? req_b[gi*MASKWIDTH +: MASKWIDTH] : '0;
    end

    always_comb begin
        ib_next = '0;
        for (int i = 0; i < NREQ; i++) begin
            ib_next = ib_next | gated_b[i];
        end
    end

    assign req_rdy  = grant;
    assign p_dvld   = |grant;
    assign p_ib     = ib_next;
    assign tail_vld = tag_vld_reg[LAT-1];
    assign tail_tag = tag_reg[LAT-1];
    assign load     = ena & p_ovld;
    assign retire   = ena & tail_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= TAGW'(NREQ - 1);
        end else if (p_dvld) begin
            ptr_reg <= grant_idx;
        end
    end

    // Tag pipe mirrors the datapath: it moves only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_vld_reg[i] <= 1'b0;
                tag_reg[i]     <= '0;
            end
        end else if (ena) begin
            tag_vld_reg[0] <= p_dvld;
            tag_reg[0]     <= grant_idx;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_reg[i] <= tag_vld_reg[i-1];
                tag_reg[i]     <= tag_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_reg  <= 1'b0;
            out_tag_reg  <= '0;
            out_a_reg    <= '0;
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (load) begin
                out_vld_reg <= 1'b1;
                out_tag_reg <= tail_tag;
                out_a_reg   <= p_oa;
            end else if (out_rdy) begin
                out_vld_reg <= 1'b0;
            end
            // Tag tail and pipeline output valid must agree on every enabled cycle.
            if (ena && (p_ovld != tail_vld)) begin
                err_reg <= 1'b1;
            end
            if (p_dvld && !retire && inflight_reg != CNTW'(LAT)) begin
                inflight_reg <= inflight_reg + CNTW'(1);
            end else if (!p_dvld && retire && inflight_reg != '0) begin
                inflight_reg <= inflight_reg - CNTW'(1);
            end
        end
    end

    assign out_vld  = out_vld_reg;
    assign out_tag  = out_tag_reg;
    assign out_a    = out_a_reg;
    assign inflight = inflight_reg;
    assign err      = err_reg;

endmodule
